// File: rtl/chacha_keystream_xor.sv
// XORs a 32-bit Avalon-ST stream with one buffered 512-bit ChaCha keystream block, word by word.
// Define CHACHA_XOR_EOP_DISCARD_EN to drop unused keystream words at end-of-packet.
module chacha_keystream_xor (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [511:0] ks_data,
    input  logic         ks_valid,
    output logic         ks_ready,
    input  logic [31:0]  in_data,
    input  logic         in_valid,
    input  logic         in_endofpacket,
    output logic         in_ready,
    output logic [31:0]  out_data,
    output logic         out_valid,
    output logic         out_endofpacket,
    input  logic         out_ready,
    input  logic         csr_write,
    input  logic         csr_read,
    input  logic [1:0]   csr_address,
    input  logic [31:0]  csr_writedata,
    output logic [31:0]  csr_readdata
);

    localparam logic [31:0] CSR_MAGIC = 32'h5EED_0C20;

    typedef enum logic {
        EMPTY  = 1'b0,
        LOADED = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [15:0][31:0] ks_buf;
    logic [3:0]        idx;
    logic [31:0]       words_cnt;
    logic [31:0]       blocks_cnt;
    logic [31:0]       csr_mux;
    logic              flush_cmd;
    logic              clear_cmd;
    logic              ks_take;
    logic              xfer;
    logic              block_done;

    assign flush_cmd = csr_write && (csr_address == 2'd3);
    assign clear_cmd = csr_write && (csr_address == 2'd0) && csr_writedata[0];

    assign ks_ready  = (state == EMPTY);
    assign in_ready  = (state == LOADED) && (!out_valid || out_ready) && !flush_cmd;
    // A flush discards a block offered in the same cycle; the sender must re-present it.
    assign ks_take   = ks_valid && ks_ready && !flush_cmd;
    assign xfer      = in_valid && in_ready;

`ifdef CHACHA_XOR_EOP_DISCARD_EN
    assign block_done = xfer && ((idx == 4'd15) || in_endofpacket);
`else
    assign block_done = xfer && (idx == 4'd15);
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        if (flush_cmd) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY:   if (ks_take)    state_nxt = LOADED;
                LOADED:  if (block_done) state_nxt = EMPTY;
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= EMPTY;
        else          state <= state_nxt;
    end

    // NOTE: the keystream buffer is reset too, so no previous key material survives a reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ks_buf <= '0;
            idx    <= 4'd0;
        end else if (flush_cmd) begin
            idx <= 4'd0;
        end else if (ks_take) begin
            ks_buf <= ks_data;
            idx    <= 4'd0;
        end else if (xfer) begin
            idx <= block_done ? 4'd0 : idx + 4'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_data        <= 32'd0;
            out_endofpacket <= 1'b0;
            out_valid       <= 1'b0;
        end else if (flush_cmd) begin
            out_valid <= 1'b0;
        end else if (xfer) begin
            out_data        <= in_data ^ ks_buf[idx];
            out_endofpacket <= in_endofpacket;
            out_valid       <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Clearing takes priority over a same-cycle increment.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            words_cnt  <= 32'd0;
            blocks_cnt <= 32'd0;
        end else if (clear_cmd) begin
            words_cnt  <= 32'd0;
            blocks_cnt <= 32'd0;
        end else begin
            if (xfer)    words_cnt  <= words_cnt + 32'd1;
            if (ks_take) blocks_cnt <= blocks_cnt + 32'd1;
        end
    end

    always_comb begin
        csr_mux = 32'd0;
        case (csr_address)
            2'd0:    csr_mux = words_cnt;
            2'd1:    csr_mux = blocks_cnt;
            2'd2:    csr_mux = {29'd0, out_valid, state == LOADED, idx == 4'd0};
            default: csr_mux = CSR_MAGIC;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)      csr_readdata <= 32'd0;
        else if (csr_read) csr_readdata <= csr_mux;
    end

endmodule

// File: tb/tb_chacha_keystream_xor.sv
// Scoreboard bench for chacha_keystream_xor: a queue-based keystream model predicts every
// output word, handshake and CSR read; a monitor compares while directed and random stimulus runs.
module tb_chacha_keystream_xor;

    logic         clock;
    logic         reset_n;
    logic [511:0] ks_data;
    logic         ks_valid;
    logic         ks_ready;
    logic [31:0]  in_data;
    logic         in_valid;
    logic         in_endofpacket;
    logic         in_ready;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_endofpacket;
    logic         out_ready;
    logic         csr_write;
    logic         csr_read;
    logic [1:0]   csr_address;
    logic [31:0]  csr_writedata;
    logic [31:0]  csr_readdata;

    chacha_keystream_xor dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .ks_data         (ks_data),
        .ks_valid        (ks_valid),
        .ks_ready        (ks_ready),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_endofpacket  (in_endofpacket),
        .in_ready        (in_ready),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_endofpacket (out_endofpacket),
        .out_ready       (out_ready),
        .csr_write       (csr_write),
        .csr_read        (csr_read),
        .csr_address     (csr_address),
        .csr_writedata   (csr_writedata),
        .csr_readdata    (csr_readdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the keystream words not yet used, the outputs not yet consumed, counters.
    typedef struct {
        logic [31:0] data;
        logic        eop;
    } exp_t;

    logic [31:0] ks_q[$];
    exp_t        exp_q[$];
    logic [31:0] words_m;
    logic [31:0] blocks_m;
    logic        csr_pend;
    logic [31:0] csr_exp;
    logic        mon_en;

    logic        m_flush;
    logic        m_clr;
    logic        m_ov;
    logic        m_have;
    exp_t        m_e;

    task automatic model_reset();
        ks_q.delete();
        exp_q.delete();
        words_m  = 32'd0;
        blocks_m = 32'd0;
        csr_pend = 1'b0;
    endtask

    always @(negedge clock) begin
        #4;
        if (mon_en && reset_n) begin
            m_flush = csr_write && (csr_address == 2'd3);
            m_clr   = csr_write && (csr_address == 2'd0) && csr_writedata[0];
            if (csr_pend) begin
                check("csr_readdata", csr_readdata, csr_exp);
                csr_pend = 1'b0;
            end
            m_ov   = (exp_q.size() != 0);
            m_have = (ks_q.size() != 0);
            check("out_valid", 32'(out_valid), 32'(m_ov));
            check("ks_ready", 32'(ks_ready), 32'(!m_have));
            check("in_ready", 32'(in_ready), 32'(m_have && (!m_ov || out_ready) && !m_flush));
            if (csr_read) begin
                csr_pend = 1'b1;
                case (csr_address)
                    2'd0:    csr_exp = words_m;
                    2'd1:    csr_exp = blocks_m;
                    2'd2:    csr_exp = {29'd0, m_ov, m_have, (ks_q.size() == 0) || (ks_q.size() == 16)};
                    default: csr_exp = 32'h5EED0C20;
                endcase
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("out_unexpected", 32'(out_valid), 32'd0);
                end else begin
                    m_e = exp_q.pop_front();
                    check("out_data", out_data, m_e.data);
                    check("out_eop", 32'(out_endofpacket), 32'(m_e.eop));
                end
            end
            if (m_flush) begin
                exp_q.delete();
                ks_q.delete();
            end else begin
                if (in_valid && in_ready) begin
                    if (ks_q.size() == 0) begin
                        check("in_ready_without_ks", 32'(in_ready), 32'd0);
                    end else begin
                        m_e.data = in_data ^ ks_q.pop_front();
                        m_e.eop  = in_endofpacket;
                        exp_q.push_back(m_e);
`ifdef CHACHA_XOR_EOP_DISCARD_EN
                        if (in_endofpacket) ks_q.delete();
`endif
                    end
                    words_m = words_m + 32'd1;
                end
                if (ks_valid && ks_ready) begin
                    for (int i = 0; i < 16; i++) ks_q.push_back(ks_data[32*i +: 32]);
                    blocks_m = blocks_m + 32'd1;
                end
            end
            if (m_clr) begin
                words_m  = 32'd0;
                blocks_m = 32'd0;
            end
        end
    end

    // Driver tasks start and end on a falling edge.
    task automatic rand_block(output logic [511:0] blk);
        for (int i = 0; i < 16; i++) blk[32*i +: 32] = $urandom;
    endtask

    task automatic load_block(input logic [511:0] blk);
        logic acc;
        acc      = 1'b0;
        ks_valid = 1'b1;
        ks_data  = blk;
        for (int t = 0; t < 60 && !acc; t++) begin
            #4 acc = ks_ready;
            @(negedge clock);
        end
        ks_valid = 1'b0;
        if (!acc) check("ks_timeout", 32'(ks_ready), 32'd1);
    endtask

    task automatic send_word(input logic [31:0] d, input logic e);
        logic acc;
        acc            = 1'b0;
        in_valid       = 1'b1;
        in_data        = d;
        in_endofpacket = e;
        for (int t = 0; t < 60 && !acc; t++) begin
            #4 acc = in_ready;
            @(negedge clock);
        end
        in_valid       = 1'b0;
        in_endofpacket = 1'b0;
        if (!acc) check("in_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
        csr_write     = 1'b1;
        csr_address   = a;
        csr_writedata = d;
        @(negedge clock);
        csr_write = 1'b0;
    endtask

    task automatic csr_rd(input string name, input logic [1:0] a, input logic [31:0] exp);
        csr_read    = 1'b1;
        csr_address = a;
        @(negedge clock);
        csr_read = 1'b0;
        check(name, csr_readdata, exp);
    endtask

    logic [511:0] blk_a;
    logic [511:0] blk_b;
    logic [31:0]  held;
    logic [31:0]  stall_word;

    initial begin
        reset_n        = 1'b0;
        mon_en         = 1'b0;
        ks_data        = '0;
        ks_valid       = 1'b0;
        in_data        = 32'd0;
        in_valid       = 1'b0;
        in_endofpacket = 1'b0;
        out_ready      = 1'b1;
        csr_write      = 1'b0;
        csr_read       = 1'b0;
        csr_address    = 2'd0;
        csr_writedata  = 32'd0;
        model_reset();

        #1;
        check("rst_ks_ready", 32'(ks_ready), 32'd1);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_eop", 32'(out_endofpacket), 32'd0);
        check("rst_csr_readdata", csr_readdata, 32'd0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        mon_en  = 1'b1;

        // Known pattern: word i = 0x01010101*i against all-ones input.
        for (int i = 0; i < 16; i++) blk_a[32*i +: 32] = 32'h01010101 * i;
        load_block(blk_a);
        for (int i = 0; i < 16; i++) send_word(32'hFFFFFFFF, 1'b0);
        @(negedge clock);
        csr_rd("words_after_block", 2'd0, 32'd16);
        csr_rd("blocks_after_block", 2'd1, 32'd1);
        csr_rd("magic", 2'd3, 32'h5EED0C20);

        // Back-to-back blocks, full-rate sink.
        rand_block(blk_a);
        rand_block(blk_b);
        fork
            begin
                load_block(blk_a);
                load_block(blk_b);
            end
            begin
                for (int i = 0; i < 32; i++) send_word($urandom, 1'b0);
            end
        join

        // Backpressure mid-block.
        rand_block(blk_a);
        load_block(blk_a);
        for (int i = 0; i < 4; i++) send_word($urandom, 1'b0);
        out_ready  = 1'b0;
        held       = out_data;
        stall_word = $urandom;
        in_valid   = 1'b1;
        in_data    = stall_word;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("stall_out_data", out_data, held);
            check("stall_out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        send_word(stall_word, 1'b0);
        for (int i = 0; i < 11; i++) send_word($urandom, 1'b0);

        // Three-word packet followed by a new packet.
        rand_block(blk_a);
        load_block(blk_a);
        send_word($urandom, 1'b0);
        send_word($urandom, 1'b0);
        send_word($urandom, 1'b1);
`ifdef CHACHA_XOR_EOP_DISCARD_EN
        check("eop_ks_ready", 32'(ks_ready), 32'd1);
        rand_block(blk_b);
        fork
            load_block(blk_b);
            begin
                send_word($urandom, 1'b0);
                send_word($urandom, 1'b1);
            end
        join
`else
        check("eop_ks_ready", 32'(ks_ready), 32'd0);
        send_word($urandom, 1'b0);
        send_word($urandom, 1'b1);
        for (int i = 0; i < 11; i++) send_word($urandom, 1'b0);
`endif

        // Flush with a word offered at idx 5.
        csr_wr(2'd3, 32'd0);
        rand_block(blk_a);
        load_block(blk_a);
        for (int i = 0; i < 5; i++) send_word($urandom, 1'b0);
        in_valid    = 1'b1;
        in_data     = $urandom;
        csr_write   = 1'b1;
        csr_address = 2'd3;
        @(negedge clock);
        csr_write = 1'b0;
        in_valid  = 1'b0;
        check("flush_ks_ready", 32'(ks_ready), 32'd1);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        csr_rd("flush_status", 2'd2, 32'd1);

        // Counter clear.
        csr_wr(2'd0, 32'd1);
        csr_rd("clear_words", 2'd0, 32'd0);
        csr_rd("clear_blocks", 2'd1, 32'd0);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            ks_valid = ($urandom_range(0, 2) == 0);
            rand_block(blk_a);
            ks_data        = blk_a;
            in_valid       = ($urandom_range(0, 3) != 0);
            in_data        = $urandom;
            in_endofpacket = ($urandom_range(0, 7) == 0);
            out_ready      = ($urandom_range(0, 3) != 0);
            csr_read       = ($urandom_range(0, 7) == 0);
            csr_write      = ($urandom_range(0, 39) == 0);
            csr_address    = 2'($urandom_range(0, 3));
            csr_writedata  = $urandom;
        end
        @(negedge clock);
        ks_valid  = 1'b0;
        in_valid  = 1'b0;
        csr_read  = 1'b0;
        csr_write = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clock);

        // Asynchronous reset in the middle of a block.
        csr_wr(2'd3, 32'd0);
        rand_block(blk_a);
        load_block(blk_a);
        for (int i = 0; i < 3; i++) send_word($urandom, 1'b0);
        csr_rd("pre_reset_magic", 2'd3, 32'h5EED0C20);
        in_valid = 1'b1;
        in_data  = $urandom;
        #2;
        mon_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        check("async_ks_ready", 32'(ks_ready), 32'd1);
        check("async_in_ready", 32'(in_ready), 32'd0);
        check("async_out_valid", 32'(out_valid), 32'd0);
        check("async_out_data", out_data, 32'd0);
        check("async_out_eop", 32'(out_endofpacket), 32'd0);
        check("async_csr_readdata", csr_readdata, 32'd0);
        in_valid = 1'b0;
        @(negedge clock);
        model_reset();
        reset_n = 1'b1;
        mon_en  = 1'b1;
        csr_rd("post_reset_status", 2'd2, 32'd1);
        csr_rd("post_reset_words", 2'd0, 32'd0);
        csr_rd("post_reset_blocks", 2'd1, 32'd0);
        repeat (2) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
